// File: rtl/mips_divider.sv
// Iterative restoring divider for MIPS32 DIV/DIVU; one quotient bit per cycle with signed pre/post correction.
// Latency: 33 cycles from the start edge to done (32 RUN steps plus one FIX step).
// Backpressure: none; busy stalls the pipeline, a new start aborts and restarts any operation in flight.
module mips_divider (
    input  logic        clock,
    input  logic        reset,
    input  logic        op_div,
    input  logic        op_divu,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_n;

    // Iteration counter: counts RUN steps 0..31.
    logic [4:0]  count;
    logic [4:0]  count_n;

    // Working registers. quo_shift starts as the dividend magnitude and is
    // shifted out at the top while quotient bits are shifted in at the bottom,
    // so after 32 steps it holds the quotient magnitude.
    logic [31:0] part_rem;
    logic [31:0] part_rem_n;
    logic [31:0] quo_shift;
    logic [31:0] quo_shift_n;
    logic [31:0] div_mag;
    logic [31:0] div_mag_n;
    logic        neg_q;
    logic        neg_q_n;
    logic        neg_r;
    logic        neg_r_n;

    logic [31:0] quotient_n;
    logic [31:0] remainder_n;
    logic        busy_n;
    logic        done_n;

    // Start decode and operand magnitudes; op_div takes priority over op_divu.
    logic        start;
    logic        signed_op;
    logic [31:0] dvd_mag;
    logic [31:0] dvs_mag;

    assign start     = op_div | op_divu;
    assign signed_op = op_div;
    assign dvd_mag   = (signed_op && dividend[31]) ? (32'd0 - dividend) : dividend;
    assign dvs_mag   = (signed_op && divisor[31])  ? (32'd0 - divisor)  : divisor;

    // One restoring step. The shifted partial remainder is 33 bits wide; when
    // its top bit (part_rem[31]) is set it exceeds any 32-bit divisor, so the
    // subtraction always succeeds and the low 32 bits of the difference are exact.
    logic [31:0] shifted;
    logic [31:0] trial;
    logic        take;

    assign shifted = {part_rem[30:0], quo_shift[31]};
    assign trial   = shifted - div_mag;
    assign take    = part_rem[31] | (shifted >= div_mag);

    // Next-state and datapath update: start overrides everything, else advance the FSM.
    always_comb begin
        state_n     = state;
        count_n     = count;
        part_rem_n  = part_rem;
        quo_shift_n = quo_shift;
        div_mag_n   = div_mag;
        neg_q_n     = neg_q;
        neg_r_n     = neg_r;
        quotient_n  = quotient;
        remainder_n = remainder;
        done_n      = 1'b0;

        if (start) begin
            // A start in RUN or FIX abandons the old operation silently;
            // results keep their previous values and no done is raised.
            state_n     = RUN;
            count_n     = 5'd0;
            part_rem_n  = 32'd0;
            quo_shift_n = dvd_mag;
            div_mag_n   = dvs_mag;
            neg_q_n     = signed_op & (dividend[31] ^ divisor[31]);
            neg_r_n     = signed_op & dividend[31];
        end else begin
            case (state)
                RUN: begin
                    if (take) begin
                        part_rem_n  = trial;
                        quo_shift_n = {quo_shift[30:0], 1'b1};
                    end else begin
                        part_rem_n  = shifted;
                        quo_shift_n = {quo_shift[30:0], 1'b0};
                    end
                    count_n = count + 5'd1;
                    if (count == 5'd31) begin
                        state_n = FIX;
                    end
                end
                FIX: begin
                    // Sign correction; a 0x80000000 magnitude negates to itself,
                    // which gives the architected overflow result.
                    quotient_n  = neg_q ? (32'd0 - quo_shift) : quo_shift;
                    remainder_n = neg_r ? (32'd0 - part_rem)  : part_rem;
                    done_n      = 1'b1;
                    state_n     = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end

        // busy is registered from the next state, so it has no combinational
        // path from the start pulses and is already high the cycle after E0.
        busy_n = (state_n != IDLE);
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= 5'd0;
            part_rem  <= 32'd0;
            quo_shift <= 32'd0;
            div_mag   <= 32'd0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            quotient  <= 32'd0;
            remainder <= 32'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            part_rem  <= part_rem_n;
            quo_shift <= quo_shift_n;
            div_mag   <= div_mag_n;
            neg_q     <= neg_q_n;
            neg_r     <= neg_r_n;
            quotient  <= quotient_n;
            remainder <= remainder_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

endmodule

// File: tb/tb_mips_divider.sv
// Scoreboard bench for mips_divider: stimulus pushes expected results, a monitor checks each done.
// Directed hand-computed vectors, then a back-to-back chain of random operations against a model.
// Every wait on the DUT is bounded; a timeout counts as a failed comparison.
module tb_mips_divider;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        op_div = 1'b0;
    logic        op_divu = 1'b0;
    logic [31:0] dividend = 32'd0;
    logic [31:0] divisor = 32'd0;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;

    mips_divider dut (
        .clock     (clock),
        .reset     (reset),
        .op_div    (op_div),
        .op_divu   (op_divu),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          at;
    } exp_t;

    exp_t scb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (!reset && done) begin
            chk("done_without_busy", {31'd0, busy}, 32'd0);
            if (scb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1, expected no completion (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = scb.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("latency_cycle", cyc, e.at);
            end
        end
    end

    // Drive a start pulse at the current (negedge) instant; returns at the
    // negedge following the start edge E0. Done is expected 34 cycle-counts on.
    task automatic drive(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input bit expect_done, input logic [31:0] eq, input logic [31:0] er);
        exp_t e;
        op_div   = sgn;
        op_divu  = !sgn;
        dividend = a;
        divisor  = b;
        if (expect_done) begin
            e.q  = eq;
            e.r  = er;
            e.at = cyc + 34;
            scb.push_back(e);
        end
        @(negedge clock);
        op_div   = 1'b0;
        op_divu  = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    // Returns at the negedge where done is high, or reports a timeout.
    task automatic wait_done(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got no done in 40 cycles, expected done", name);
        end
    endtask

    function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sd;
        logic signed [31:0] q;
        logic signed [31:0] r;
        if (!sgn) begin
            if (b == 32'd0) return {32'hFFFFFFFF, a};
            return {a / b, a % b};
        end
        if (b == 32'd0) return {(a[31] ? 32'h00000001 : 32'hFFFFFFFF), a};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h80000000, 32'h00000000};
        sa = a;
        sd = b;
        q  = sa / sd;
        r  = sa % sd;
        return {q, r};
    endfunction

    initial begin
        logic [63:0] m;
        bit          sg;
        logic [31:0] a;
        logic [31:0] b;

        // Reset state
        #1 reset = 1'b1;
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_quotient", quotient, 32'd0);
        chk("reset_remainder", remainder, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Unsigned basic with busy profile over the 33 intervening cycles
        drive(1'b0, 32'd100, 32'd7, 1'b1, 32'h0000000E, 32'h00000002);
        chk("busy_after_e0", {31'd0, busy}, 32'd1);
        for (int i = 1; i < 33; i++) begin
            @(negedge clock);
            chk("busy_during_run", {31'd0, busy}, 32'd1);
        end
        wait_done("divu_100_7");
        chk("busy_at_done", {31'd0, busy}, 32'd0);

        // Signed sign cases and corner operands, each issued in the done cycle
        drive(1'b1, 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF);
        wait_done("div_m7_2");
        drive(1'b1, 32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'h00000001);
        wait_done("div_7_m2");
        drive(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 32'h00000003, 32'hFFFFFFFF);
        wait_done("div_m7_m2");
        drive(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'h00000000);
        wait_done("div_overflow");
        drive(1'b0, 32'hFFFFFFFF, 32'd1, 1'b1, 32'hFFFFFFFF, 32'h00000000);
        wait_done("divu_max_1");
        drive(1'b0, 32'd5, 32'd0, 1'b1, 32'hFFFFFFFF, 32'h00000005);
        wait_done("divu_5_0");
        drive(1'b1, 32'hFFFFFFF6, 32'd0, 1'b1, 32'h00000001, 32'hFFFFFFF6);
        wait_done("div_m10_0");
        drive(1'b0, 32'd5, 32'd0, 1'b1, 32'hFFFFFFFF, 32'h00000005);
        wait_done("divu_5_0_again");
        @(negedge clock);

        // Restart: abandoned 1000/10, then 81/9 at cycle 10; results held meanwhile
        drive(1'b0, 32'd1000, 32'd10, 1'b0, 32'd0, 32'd0);
        repeat (8) @(negedge clock);
        chk("hold_q_before_restart", quotient, 32'hFFFFFFFF);
        chk("hold_r_before_restart", remainder, 32'h00000005);
        @(negedge clock);
        drive(1'b0, 32'd81, 32'd9, 1'b1, 32'd9, 32'd0);
        repeat (32) @(negedge clock);
        chk("hold_q_after_restart", quotient, 32'hFFFFFFFF);
        chk("hold_r_after_restart", remainder, 32'h00000005);
        chk("done_low_before_e33", {31'd0, done}, 32'd0);
        wait_done("restart_81_9");
        repeat (2) @(negedge clock);

        // Asynchronous reset mid-RUN, between clock edges
        drive(1'b0, 32'd1000, 32'd3, 1'b0, 32'd0, 32'd0);
        repeat (5) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_quotient", quotient, 32'd0);
        chk("arst_remainder", remainder, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        drive(1'b0, 32'd9, 32'd4, 1'b1, 32'd2, 32'd1);
        wait_done("divu_9_4");

        // Back-to-back chain: hand case, then random pairs against the model
        drive(1'b1, 32'hFFFFFF9C, 32'd7, 1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE);
        wait_done("div_m100_7");
        for (int i = 0; i < 64; i++) begin
            sg = $urandom_range(0, 1);
            a  = $urandom;
            case ($urandom_range(0, 4))
                0: b = $urandom_range(1, 15);
                1: b = 32'd0 - $urandom_range(1, 15);
                2: b = 32'd0;
                3: b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            if (i == 5) a = 32'h80000000;
            m = model(sg, a, b);
            drive(sg, a, b, 1'b1, m[63:32], m[31:0]);
            wait_done("random");
        end

        repeat (3) @(negedge clock);
        chk("scoreboard_drained", scb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
